// File: rtl/screen_fb_pkg.sv
// Shared frame-buffer geometry and pixel packing rules for the screen RAM.
// Used by the pixel writer and by the scan-out reader so both sides agree
// on word addressing and nibble placement.
package screen_fb_pkg;

    localparam int FB_WIDTH     = 488;
    localparam int FB_HEIGHT    = 280;
    localparam int PIX_PER_WORD = 8;
    localparam int FB_WORDS     = FB_WIDTH * FB_HEIGHT / PIX_PER_WORD;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_MRG  = 3'd2,
        ST_WR   = 3'd3,
        ST_FILL = 3'd4
    } wr_state_t;

    // Pixel x[2:0]=4 lands in the lowest nibble, x[2:0]=3 in the highest.
    function automatic logic [2:0] lane_of(input logic [2:0] xl);
        return xl + 3'd4;
    endfunction

endpackage

// File: rtl/nibble_merge.sv
// Replaces one 4-bit pixel lane of a packed memory word with a new colour.
module nibble_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [2:0]            lane,
    input  logic [3:0]            color,
    output logic [DATA_WIDTH-1:0] merged
);

    localparam int LANES = DATA_WIDTH / 4;

    // Copy the word and overwrite only the selected nibble.
    always_comb begin
        merged = word;
        for (int i = 0; i < LANES; i++) begin
            if (3'(i) == lane) merged[4*i +: 4] = color;
        end
    end

endmodule

// File: rtl/screen_ram_writer.sv
// Pixel writer for the 4bpp screen frame buffer. Each pixel request is a
// read-modify-write of the 32-bit word holding the pixel (RD -> MRG -> WR).
// Optional whole-buffer clear is compiled in when SCREEN_WR_FILL_EN is
// defined; otherwise req_fill is ignored and every request is a pixel write.
module screen_ram_writer #(
    parameter int SCREEN_WIDTH = 11,
    parameter int ADDR_WIDTH   = 25,
    parameter int DATA_WIDTH   = 32,
    parameter int FB_WIDTH     = 488,
    parameter int FB_HEIGHT    = 280,
    parameter int START_ADDR   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_fill,
    input  logic [SCREEN_WIDTH-1:0] req_x,
    input  logic [SCREEN_WIDTH-1:0] req_y,
    input  logic [3:0]              req_color,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_rd_en,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_wr_en,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic                    done,
    output logic                    drop
);

    import screen_fb_pkg::*;

    localparam logic [SCREEN_WIDTH-1:0] X_LIM = SCREEN_WIDTH'(FB_WIDTH);
    localparam logic [SCREEN_WIDTH-1:0] Y_LIM = SCREEN_WIDTH'(FB_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0]   BASE  = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0]   ROW   = ADDR_WIDTH'(FB_WIDTH);

    wr_state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            lane_q;
    logic [3:0]            color_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] merged;
    logic                  drop_q;

    logic                  accept;
    logic                  in_range;
    logic                  is_fill;
    logic [ADDR_WIDTH-1:0] pix_addr;

    assign accept   = req_valid && (state == ST_IDLE);
    assign in_range = (req_x < X_LIM) && (req_y < Y_LIM);
    // Rows are whole words (width is a multiple of 8), so the linear pixel
    // index shifted down by 3 is the word offset.
    assign pix_addr = BASE + ((ADDR_WIDTH'(req_y) * ROW + ADDR_WIDTH'(req_x)) >> 3);

`ifdef SCREEN_WR_FILL_EN
    localparam int WORDS = FB_WIDTH * FB_HEIGHT / 8;
    localparam int CNT_W = $clog2(WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

    logic [CNT_W-1:0] cnt;
    logic             fill_last;

    assign is_fill   = req_fill;
    assign fill_last = (cnt == CNT_LAST);

    // Fill word counter: cleared on fill accept, steps once per fill write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept && is_fill) begin
            cnt <= '0;
        end else if (state == ST_FILL) begin
            cnt <= fill_last ? '0 : cnt + 1'b1;
        end
    end
`else
    logic unused_fill;

    assign is_fill     = 1'b0;
    assign unused_fill = req_fill;
`endif

    nibble_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
        .word   (mem_rdata),
        .lane   (lane_q),
        .color  (color_q),
        .merged (merged)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_fill)       state_nxt = ST_FILL;
                    else if (in_range) state_nxt = ST_RD;
                end
            end
            ST_RD:   state_nxt = ST_MRG;
            ST_MRG:  state_nxt = ST_WR;
            ST_WR:   state_nxt = ST_IDLE;
`ifdef SCREEN_WR_FILL_EN
            ST_FILL: if (fill_last) state_nxt = ST_IDLE;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request capture, merge register and drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            lane_q  <= '0;
            color_q <= '0;
            wdata_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= accept && !is_fill && !in_range;
            if (accept) begin
                addr_q  <= pix_addr;
                lane_q  <= lane_of(req_x[2:0]);
                color_q <= req_color;
            end
            if (state == ST_MRG) wdata_q <= merged;
        end
    end

    // Memory strobes and handshake outputs decoded from the current state.
    always_comb begin
        req_ready = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = 1'b0;
        case (state)
            ST_IDLE: req_ready = 1'b1;
            ST_RD: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr_q;
            end
            ST_MRG:  mem_addr = addr_q;
            ST_WR: begin
                mem_wr_en = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                done      = 1'b1;
            end
`ifdef SCREEN_WR_FILL_EN
            ST_FILL: begin
                mem_wr_en = 1'b1;
                mem_addr  = BASE + ADDR_WIDTH'(cnt);
                mem_wdata = {(DATA_WIDTH/4){color_q}};
                done      = fill_last;
            end
`endif
            default: ;
        endcase
    end

    assign drop = drop_q;

endmodule

// File: tb/tb_screen_ram_writer.sv
// Scoreboard bench for screen_ram_writer: a pixel-level frame-buffer model
// predicts every memory write and drop pulse; a negedge monitor compares.
module tb_screen_ram_writer;

    localparam int W  = 488;
    localparam int H  = 280;
    localparam int NW = W * H / 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_fill = 1'b0;
    logic [10:0] req_x = '0;
    logic [10:0] req_y = '0;
    logic [3:0]  req_color = '0;
    logic [24:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata = '0;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic        done;
    logic        drop;

    always #5 clk = ~clk;

    screen_ram_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_fill  (req_fill),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_color (req_color),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .done      (done),
        .drop      (drop)
    );

    // Word-addressed screen RAM with one-cycle read latency.
    logic [31:0] mem [NW];
    int maddr;
    assign maddr = int'(mem_addr);

    always @(posedge clk) begin
        if (mem_rd_en && maddr < NW) mem_rdata <= mem[maddr];
        if (mem_wr_en && maddr < NW) mem[maddr] <= mem_wdata;
    end

    // Reference: the frame buffer as a 2-D pixel array.
    logic [3:0] pix [H][W];

    typedef struct {
        bit          is_drop;
        int          addr;
        logic [31:0] data;
        bit          done;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Pack the eight pixels of word idx: pixel k of the group sits in
    // nibble (k+4) mod 8.
    function automatic logic [31:0] word_at(int idx);
        logic [31:0] w;
        int y, x0;
        y  = (idx * 8) / W;
        x0 = (idx * 8) % W;
        w  = '0;
        for (int k = 0; k < 8; k++) w[4*((k+4)%8) +: 4] = pix[y][x0+k];
        return w;
    endfunction

    task automatic model(bit fill, int x, int y, logic [3:0] c);
        bit fe;
        exp_t e;
`ifdef SCREEN_WR_FILL_EN
        fe = 1'b1;
`else
        fe = 1'b0;
`endif
        if (fill && fe) begin
            for (int yy = 0; yy < H; yy++)
                for (int xx = 0; xx < W; xx++) pix[yy][xx] = c;
            for (int i = 0; i < NW; i++) begin
                e = '{1'b0, i, word_at(i), (i == NW-1)};
                q.push_back(e);
            end
        end else if (x >= W || y >= H) begin
            e = '{1'b1, 0, 32'h0, 1'b0};
            q.push_back(e);
        end else begin
            pix[y][x] = c;
            e = '{1'b0, (y*W + x) / 8, word_at((y*W + x) / 8), 1'b1};
            q.push_back(e);
        end
    endtask

    // Monitor: every write or drop must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (mem_rd_en && mem_wr_en) chk("rd_wr_overlap", 32'd1, 32'd0);
            if (done && !mem_wr_en)     chk("done_no_write", 32'd1, 32'd0);
            if (mem_wr_en || drop) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", {30'd0, mem_wr_en, drop}, 32'd0);
                end else begin
                    e = q.pop_front();
                    if (e.is_drop) begin
                        chk("drop", {31'd0, drop}, 32'd1);
                        chk("drop_no_write", {31'd0, mem_wr_en}, 32'd0);
                    end else begin
                        chk("wr_en", {31'd0, mem_wr_en}, 32'd1);
                        chk("wr_addr", {7'd0, mem_addr}, 32'(e.addr));
                        chk("wr_data", mem_wdata, e.data);
                        chk("wr_done", {31'd0, done}, {31'd0, e.done});
                    end
                end
            end
        end
    end

    // Present a request, hold it until accepted, optionally update the model.
    task automatic issue(bit fill, int x, int y, logic [3:0] c, bit push);
        int n;
        bit r;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_fill  = fill;
        req_x     = 11'(x);
        req_y     = 11'(y);
        req_color = c;
        forever begin
            r = req_ready;
            @(posedge clk);
            if (r) break;
            n++;
            if (n > 20000) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
            @(negedge clk);
        end
        if (push) model(fill, x, y, c);
        #1;
        req_valid = 1'b0;
        req_fill  = 1'b0;
    endtask

    // Pixel write with cycle-exact strobe checks against fixed values.
    task automatic timed_pixel(int x, int y, logic [3:0] c, int a, logic [31:0] wd);
        issue(1'b0, x, y, c, 1'b1);
        @(negedge clk);
        chk("c1_rd_en", {31'd0, mem_rd_en}, 32'd1);
        chk("c1_addr", {7'd0, mem_addr}, 32'(a));
        chk("c1_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("c2_strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        @(negedge clk);
        chk("c3_wr_en", {31'd0, mem_wr_en}, 32'd1);
        chk("c3_done", {31'd0, done}, 32'd1);
        chk("c3_addr", {7'd0, mem_addr}, 32'(a));
        chk("c3_wdata", mem_wdata, wd);
        @(negedge clk);
        chk("c4_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < NW; i++) mem[i] = $urandom;
        mem[0]   = 32'h12345678;
        mem[123] = 32'h0;
        for (int i = 0; i < NW; i++)
            for (int k = 0; k < 8; k++)
                pix[(i*8)/W][(i*8)%W + k] = mem[i][4*((k+4)%8) +: 4];

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_strobes", {28'd0, mem_rd_en, mem_wr_en, done, drop}, 32'd0);
        chk("rst_addr", {7'd0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;

        timed_pixel(4, 0, 4'hA, 0, 32'h1234567A);
        timed_pixel(11, 2, 4'hF, 123, 32'hF0000000);

        // Out-of-range column: drop pulse only, ready stays high.
        issue(1'b0, 488, 5, 4'h6, 1'b1);
        @(negedge clk);
        chk("drop_c1", {31'd0, drop}, 32'd1);
        chk("drop_ready", {31'd0, req_ready}, 32'd1);
        chk("drop_strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        issue(1'b0, 0, 280, 4'h2, 1'b1);
        issue(1'b0, 487, 279, 4'h9, 1'b1);

        // Reset during the merge cycle abandons the RMW with no write.
        issue(1'b0, 20, 10, 4'h5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrg_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("mrg_rst_strobes", {29'd0, mem_rd_en, mem_wr_en, done}, 32'd0);
        @(negedge clk);
        chk("mrg_rst_nowr", {31'd0, mem_wr_en}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrg_rst_idle", {30'd0, req_ready, mem_wr_en}, 32'd2);

        // Fill (pixel write when the fill feature is not built).
        issue(1'b1, 7, 1, 4'h3, 1'b1);
        for (int i = 0; i < 20000 && q.size() != 0; i++) @(negedge clk);
        chk("fill_drained", 32'(q.size()), 32'd0);
        @(negedge clk);
        chk("fill_ready", {31'd0, req_ready}, 32'd1);

        for (int n = 0; n < 150; n++) begin
            int gap;
            issue(1'b0, $urandom_range(0, W + 20), $urandom_range(0, H + 10),
                  4'($urandom), 1'b1);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) @(negedge clk);
        end

        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        chk("final_drained", 32'(q.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
